regfile_2r1w: RTL and testbench

- Register file for the midterm datapath, sitting on the consumer side of the write-back select path.
- Accepts one write per cycle (WE/WA/WD) from the write-back stage.
- Serves two registered read ports (RA1/RA2 -> RD1/RD2) to the decode/execute stage.
- Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 50 +++++
 rtl/regfile_2r1w.sv | 84 ++++++++
 tb/tb_regfile_2r1w.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

   // Register 0 is hardwired to zero
   localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode, zero-register forcing,
// optional write-before-read forwarding (REGFILE_BYPASS_EN), output register.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_rd_req,
   input  logic [ADDR_W-1:0]            i_ra,
   input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
`ifdef REGFILE_BYPASS_EN
   input  logic                         i_we,
   input  logic [ADDR_W-1:0]            i_wa,
   input  logic [DATA_W-1:0]            i_wd,
`endif
   output logic [DATA_W-1:0]            o_rd
);

   logic              w_is_zero;
   logic [DATA_W-1:0] w_rd_next;
   logic [DATA_W-1:0] r_rd;

   assign w_is_zero = (i_ra == ADDR_W'(ZERO_REG));

   // Select read data: zero register, forwarded write data, or stored value
   always_comb begin
      w_rd_next = i_mem[i_ra];
`ifdef REGFILE_BYPASS_EN
      if (i_we && (i_wa == i_ra))
         w_rd_next = i_wd;
`endif
      if (w_is_zero)
         w_rd_next = '0;
   end

   // Output register: load on request, hold otherwise, clear on reset
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_rd <= '0;
      else if (i_rd_req)
         r_rd <= w_rd_next;
   end

   assign o_rd = r_rd;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, 2 registered read ports + 1 write port, reg 0 reads zero.
// Optional write-before-read forwarding controlled by REGFILE_BYPASS_EN.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic              rd_valid,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] r_mem;
   logic                         r_rd_valid;
   logic                         w_wr_en;

   assign w_wr_en = WE && (WA != ADDR_W'(ZERO_REG));

   // Storage array: clear on reset, write non-zero addresses only
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_mem <= '0;
      else if (w_wr_en)
         r_mem[WA] <= WD;
   end

   // Read-valid flag: one cycle after each accepted request
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_rd_valid <= 1'b0;
      else
         r_rd_valid <= rd_req;
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd_port1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_rd_req (rd_req),
      .i_ra     (RA1),
      .i_mem    (r_mem),
`ifdef REGFILE_BYPASS_EN
      .i_we     (WE),
      .i_wa     (WA),
      .i_wd     (WD),
`endif
      .o_rd     (RD1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rd_port2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_rd_req (rd_req),
      .i_ra     (RA2),
      .i_mem    (r_mem),
`ifdef REGFILE_BYPASS_EN
      .i_we     (WE),
      .i_wa     (WA),
      .i_wd     (WD),
`endif
      .o_rd     (RD2)
   );

   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w: directed cases plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic        rd_req;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic        rd_valid;
   logic [31:0] RD1;
   logic [31:0] RD2;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // reference model state
   logic [31:0] m_reg [32];
   logic        m_valid;
   logic [31:0] m_rd1;
   logic [31:0] m_rd2;

   regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .WE       (WE),
      .WA       (WA),
      .WD       (WD),
      .rd_req   (rd_req),
      .RA1      (RA1),
      .RA2      (RA2),
      .rd_valid (rd_valid),
      .RD1      (RD1),
      .RD2      (RD2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] ra);
      if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (WE && WA == ra) return WD;
`endif
      return m_reg[ra];
   endfunction

   // Advance one clock, update the model with the inputs present at the edge,
   // then compare every output.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_valid = 1'b0;
         m_rd1   = '0;
         m_rd2   = '0;
      end else begin
         if (rd_req) begin
            m_rd1 = model_read(RA1);
            m_rd2 = model_read(RA2);
         end
         m_valid = rd_req;
         if (WE && WA != 5'd0) m_reg[WA] = WD;
      end
      #1;
      check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
      check("RD1", RD1, m_rd1);
      check("RD2", RD2, m_rd2);
   endtask

   task automatic idle();
      WE = 1'b0; WA = '0; WD = '0; rd_req = 1'b0; RA1 = '0; RA2 = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle(); WE = 1'b1; WA = a; WD = d;
      tick();
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      idle(); rd_req = 1'b1; RA1 = a1; RA2 = a2;
      tick();
   endtask

   initial begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_valid = 1'b0; m_rd1 = '0; m_rd2 = '0;
      rst_n = 1'b0;
      idle();
      // reset with a write and read request present: both ignored
      WE = 1'b1; WA = 5'd4; WD = 32'h1234; rd_req = 1'b1; RA1 = 5'd4;
      tick();
      tick();
      check("reset_valid", {31'b0, rd_valid}, 32'd0);
      check("reset_rd1", RD1, 32'd0);
      rst_n = 1'b1;

      // unwritten registers read zero
      rd(5'd5, 5'd31);
      check("fresh_valid", {31'b0, rd_valid}, 32'd1);
      check("fresh_rd1", RD1, 32'd0);
      check("fresh_rd2", RD2, 32'd0);

      // basic write then read
      wr(5'd7, 32'hDEADBEEF);
      rd(5'd7, 5'd7);
      check("wr7_rd1", RD1, 32'hDEADBEEF);
      check("wr7_rd2_same_addr", RD2, 32'hDEADBEEF);

      // writes to register 0 are discarded
      wr(5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd0);
      check("r0_rd1", RD1, 32'd0);
      check("r0_rd2", RD2, 32'd0);

      // hold: no request keeps previous data, drops valid
      idle();
      tick();
      check("hold_valid", {31'b0, rd_valid}, 32'd0);

      // same-cycle read and write of the same address
      wr(5'd3, 32'h11);
      idle(); WE = 1'b1; WA = 5'd3; WD = 32'h22; rd_req = 1'b1; RA1 = 5'd3; RA2 = 5'd7;
      tick();
`ifdef REGFILE_BYPASS_EN
      check("rw_same_rd1", RD1, 32'h22);
`else
      check("rw_same_rd1", RD1, 32'h11);
`endif
      rd(5'd3, 5'd0);
      check("rw_after_rd1", RD1, 32'h22);

      // back-to-back reads
      wr(5'd1, 32'd10); wr(5'd2, 32'd20); wr(5'd3, 32'd30); wr(5'd4, 32'd40);
      for (int i = 1; i <= 4; i++) begin
         rd(5'(i), 5'(5 - i));
         check("b2b_valid", {31'b0, rd_valid}, 32'd1);
         check("b2b_rd1", RD1, 32'(10 * i));
      end

      // reset while read in flight
      wr(5'd9, 32'hABCD);
      rd(5'd9, 5'd9);
      check("pre_rst_rd1", RD1, 32'hABCD);
      idle(); rst_n = 1'b0; rd_req = 1'b1; RA1 = 5'd9;
      tick();
      check("rst_flight_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_flight_rd1", RD1, 32'd0);
      rst_n = 1'b1;
      rd(5'd9, 5'd1);
      check("post_rst_rd1", RD1, 32'd0);
      check("post_rst_rd2", RD2, 32'd0);

      // randomized traffic; small address range on some cycles for collisions
      for (int n = 0; n < 600; n++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         WE     = $urandom_range(0, 1);
         rd_req = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) != 0) begin
            WA  = 5'($urandom_range(0, 3));
            RA1 = 5'($urandom_range(0, 3));
            RA2 = 5'($urandom_range(0, 3));
         end else begin
            WA  = 5'($urandom);
            RA1 = 5'($urandom);
            RA2 = 5'($urandom);
         end
         WD = $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
